struct_s2_serializer: RTL and testbench

STRUCT_S2_SERIALIZER -- requirements
Module: struct_s2_serializer

---
 rtl/struct_s2_serializer_if.sv | 19 +
 rtl/struct_s2_serializer.sv | 54 +++++
 tb/tb_struct_s2_serializer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/struct_s2_serializer_if.sv
// struct_s2_serializer_if: record-in / byte-out handshake bundle for the s2 serializer
interface struct_s2_serializer_if;
  logic [37:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [7:0]  frame_cnt;
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_cnt
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_cnt
  );
endinterface

// File: rtl/struct_s2_serializer.sv
// struct_s2_serializer: captures a 38-bit s2 record and emits it as 5 bytes plus optional XOR checksum
module struct_s2_serializer #(
  parameter bit CSUM_EN   = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  struct_s2_serializer_if.slave s
);
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
  state_t      state, state_n;
  logic [39:0] sr;
  logic [2:0]  idx;
  logic [7:0]  csum;
  logic [7:0]  cnt;
  logic [7:0]  cur;
  logic        acc;
  logic        cap;
  assign cur         = MSB_FIRST ? sr[39:32] : sr[7:0];
  assign acc         = s.out_valid && s.out_ready;
  assign cap         = s.in_valid && s.in_ready;
  assign s.in_ready  = state == IDLE;
  assign s.out_valid = state != IDLE;
  assign s.out_data  = state == SEND ? cur : state == CSUM ? csum : 8'h00;
  assign s.out_last  = state == CSUM || (state == SEND && idx == 3'd4 && !CSUM_EN);
  assign s.frame_cnt = cnt;
  always_comb begin
    state_n = state;
    if (state == IDLE && s.in_valid) state_n = SEND;
    else if (state == SEND && acc && idx == 3'd4) state_n = CSUM_EN ? CSUM : IDLE;
    else if (state == CSUM && acc) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      idx   <= '0;
      csum  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (cap) begin
        sr   <= {2'b00, s.in_data};
        idx  <= '0;
        csum <= '0;
      end else if (acc && state == SEND) begin
        sr   <= MSB_FIRST ? sr << 8 : sr >> 8;
        idx  <= idx + 3'd1;
        csum <= csum ^ cur;
      end
      if (acc && s.out_last) cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_struct_s2_serializer.sv
// tb_struct_s2_serializer: three parameter variants driven in lockstep, checked against a byte-stream model
module tb_struct_s2_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic [37:0] id = '0;
  logic        ordy = 1'b1;
  logic [2:0]  rdy, vld, lst;
  logic [7:0]  dat [3];
  logic [7:0]  fc [3];
  logic [37:0] cap_q [3][$];
  int          ccy_q [3][$];
  logic [8:0]  got_q [3][$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  e_msb [6] = '{8'h11, 8'h0C, 8'hC6, 8'h44, 8'h23, 8'hBC};
  logic [7:0]  e_lsb [6] = '{8'h23, 8'h44, 8'hC6, 8'h0C, 8'h11, 8'hBC};
  always #5 clk = ~clk;
  struct_s2_serializer_if if0 ();
  struct_s2_serializer_if if1 ();
  struct_s2_serializer_if if2 ();
  struct_s2_serializer #(.CSUM_EN(1'b1), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .s(if0));
  struct_s2_serializer #(.CSUM_EN(1'b1), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .s(if1));
  struct_s2_serializer #(.CSUM_EN(1'b0), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst(rst), .s(if2));
  assign if0.in_data = id;
  assign if1.in_data = id;
  assign if2.in_data = id;
  assign if0.in_valid = iv;
  assign if1.in_valid = iv;
  assign if2.in_valid = iv;
  assign if0.out_ready = ordy;
  assign if1.out_ready = ordy;
  assign if2.out_ready = ordy;
  assign rdy = {if2.in_ready, if1.in_ready, if0.in_ready};
  assign vld = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign lst = {if2.out_last, if1.out_last, if0.out_last};
  assign dat[0] = if0.out_data;
  assign dat[1] = if1.out_data;
  assign dat[2] = if2.out_data;
  assign fc[0] = if0.frame_cnt;
  assign fc[1] = if1.frame_cnt;
  assign fc[2] = if2.frame_cnt;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (iv && rdy[i]) begin
          cap_q[i].push_back(id);
          ccy_q[i].push_back(cyc);
        end
        if (vld[i] && ordy) got_q[i].push_back({lst[i], dat[i]});
      end
    end
    cyc <= cyc + 1;
  end
  // variant v: 0 = defaults, 1 = LSB first, 2 = no checksum; returns {last, byte} of frame position k
  function automatic logic [8:0] exp_at(input logic [37:0] d, input int v, input int k);
    logic [39:0] p = {2'b00, d};
    logic [7:0]  b [5];
    logic [7:0]  x = 8'h00;
    int          n = (v == 2) ? 5 : 6;
    for (int j = 0; j < 5; j++) begin
      b[j] = 8'(p >> (8 * ((v == 1) ? j : 4 - j)));
      x ^= b[j];
    end
    return {k == n - 1, (k < 5) ? b[k] : x};
  endfunction
  function automatic logic [37:0] rnd38();
    return {6'($urandom), 32'($urandom)};
  endfunction
  task automatic clear_q();
    for (int i = 0; i < 3; i++) begin
      cap_q[i].delete();
      ccy_q[i].delete();
      got_q[i].delete();
    end
  endtask
  task automatic send_one(input logic [37:0] d);
    @(negedge clk);
    iv = 1'b1;
    id = d;
    @(negedge clk);
    iv = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (vld !== 3'b000 && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 400) begin
      n_err++;
      $display("FAIL drain_timeout out_valid=%b required=000", vld);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp += 5;
      if (rdy[i] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", i, rdy[i]); end
      if (vld[i] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", i, vld[i]); end
      if (lst[i] !== 1'b0) begin n_err++; $display("FAIL reset_out_last[%0d] got=%b exp=0", i, lst[i]); end
      if (dat[i] !== 8'h00) begin n_err++; $display("FAIL reset_out_data[%0d] got=%h exp=00", i, dat[i]); end
      if (fc[i] !== 8'h00) begin n_err++; $display("FAIL reset_frame_cnt[%0d] got=%0d exp=0", i, fc[i]); end
    end
    rst = 1'b0;
  endtask
  task automatic test_vectors();
    clear_q();
    send_one(38'h110CC64423);
    n_cmp++;
    if (vld !== 3'b111) begin n_err++; $display("FAIL latency_out_valid got=%b exp=111", vld); end
    drain();
    for (int i = 0; i < 3; i++) begin
      int n = (i == 2) ? 5 : 6;
      n_cmp += 2;
      if (got_q[i].size() !== n) begin n_err++; $display("FAIL vec_len[%0d] got=%0d exp=%0d", i, got_q[i].size(), n); end
      if (fc[i] !== 8'd1) begin n_err++; $display("FAIL vec_frame_cnt[%0d] got=%0d exp=1", i, fc[i]); end
      for (int k = 0; k < n; k++) begin
        logic [8:0] e = {k == n - 1, (i == 1) ? e_lsb[k] : e_msb[k]};
        n_cmp++;
        if (got_q[i][k] !== e) begin n_err++; $display("FAIL vec_byte[%0d][%0d] got=%h exp=%h", i, k, got_q[i][k], e); end
      end
    end
  endtask
  task automatic test_stall();
    int t = 0;
    clear_q();
    send_one(38'h110CC64423);
    while (got_q[0].size() < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp += 2;
    if (t >= 50) begin n_err++; $display("FAIL stall_wait_timeout got=%0d exp=2", got_q[0].size()); end
    if (dat[0] !== 8'hC6) begin n_err++; $display("FAIL stall_pre got=%h exp=c6", dat[0]); end
    ordy = 1'b0;
    id = ~id;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      id = rnd38();
      n_cmp += 2;
      if (dat[0] !== 8'hC6) begin n_err++; $display("FAIL stall_hold[%0d] got=%h exp=c6", c, dat[0]); end
      if (vld[0] !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%b exp=1", c, vld[0]); end
    end
    ordy = 1'b1;
    drain();
    n_cmp += 2;
    if (got_q[0].size() !== 6) begin n_err++; $display("FAIL stall_len got=%0d exp=6", got_q[0].size()); end
    if (fc[0] !== 8'd2) begin n_err++; $display("FAIL stall_frame_cnt got=%0d exp=2", fc[0]); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (got_q[0][k] !== {k == 5, e_msb[k]}) begin n_err++; $display("FAIL stall_byte[%0d] got=%h exp=%h", k, got_q[0][k], {k == 5, e_msb[k]}); end
    end
  endtask
  task automatic test_reset_mid();
    int t = 0;
    clear_q();
    send_one(rnd38());
    while (got_q[0].size() < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 3;
    if (t >= 50) begin n_err++; $display("FAIL rstmid_wait_timeout got=%0d exp=2", got_q[0].size()); end
    if (vld !== 3'b000) begin n_err++; $display("FAIL rstmid_out_valid got=%b exp=000", vld); end
    if (fc[0] !== 8'd0) begin n_err++; $display("FAIL rstmid_frame_cnt got=%0d exp=0", fc[0]); end
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if (got_q[0].size() !== 2) begin n_err++; $display("FAIL rstmid_no_more_bytes got=%0d exp=2", got_q[0].size()); end
    if (vld !== 3'b000) begin n_err++; $display("FAIL rstmid_idle got=%b exp=000", vld); end
    clear_q();
    send_one(rnd38());
    drain();
    for (int i = 0; i < 3; i++) begin
      int n = (i == 2) ? 5 : 6;
      n_cmp += 2;
      if (got_q[i].size() !== n) begin n_err++; $display("FAIL rstmid_len[%0d] got=%0d exp=%0d", i, got_q[i].size(), n); end
      if (fc[i] !== 8'd1) begin n_err++; $display("FAIL rstmid_frame_cnt_after[%0d] got=%0d exp=1", i, fc[i]); end
      for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (got_q[i][k] !== exp_at(cap_q[i][0], i, k)) begin n_err++; $display("FAIL rstmid_byte[%0d][%0d] got=%h exp=%h", i, k, got_q[i][k], exp_at(cap_q[i][0], i, k)); end
      end
    end
  endtask
  task automatic test_back_to_back();
    int t = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    ordy = 1'b1;
    iv = 1'b1;
    while (cap_q[0].size() < 256 && t < 3000) begin
      id = rnd38();
      @(negedge clk);
      t++;
    end
    iv = 1'b0;
    n_cmp++;
    if (t >= 3000) begin n_err++; $display("FAIL b2b_timeout got=%0d exp=256", cap_q[0].size()); end
    drain();
    n_cmp++;
    if (fc[0] !== 8'd0) begin n_err++; $display("FAIL b2b_wrap got=%0d exp=0", fc[0]); end
    for (int i = 0; i < 3; i++) begin
      int n = (i == 2) ? 5 : 6;
      int pos = 0;
      n_cmp += 2;
      if (got_q[i].size() !== cap_q[i].size() * n) begin n_err++; $display("FAIL b2b_len[%0d] got=%0d exp=%0d", i, got_q[i].size(), cap_q[i].size() * n); end
      if (fc[i] !== 8'(cap_q[i].size())) begin n_err++; $display("FAIL b2b_frame_cnt[%0d] got=%0d exp=%0d", i, fc[i], cap_q[i].size() % 256); end
      for (int j = 0; j < cap_q[i].size(); j++) begin
        if (j > 0) begin
          n_cmp++;
          if (ccy_q[i][j] - ccy_q[i][j-1] !== n + 1) begin n_err++; $display("FAIL b2b_gap[%0d][%0d] got=%0d exp=%0d", i, j, ccy_q[i][j] - ccy_q[i][j-1], n + 1); end
        end
        for (int k = 0; k < n; k++) begin
          n_cmp++;
          if (got_q[i][pos] !== exp_at(cap_q[i][j], i, k)) begin n_err++; $display("FAIL b2b_byte[%0d][%0d] got=%h exp=%h", i, pos, got_q[i][pos], exp_at(cap_q[i][j], i, k)); end
          pos++;
        end
      end
    end
  endtask
  task automatic test_random();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    for (int c = 0; c < 800; c++) begin
      iv = 1'($urandom);
      id = rnd38();
      ordy = ($urandom % 4) != 0;
      @(negedge clk);
    end
    iv = 1'b0;
    ordy = 1'b1;
    drain();
    for (int i = 0; i < 3; i++) begin
      int n = (i == 2) ? 5 : 6;
      int pos = 0;
      n_cmp += 2;
      if (got_q[i].size() !== cap_q[i].size() * n) begin n_err++; $display("FAIL rnd_len[%0d] got=%0d exp=%0d", i, got_q[i].size(), cap_q[i].size() * n); end
      if (fc[i] !== 8'(cap_q[i].size())) begin n_err++; $display("FAIL rnd_frame_cnt[%0d] got=%0d exp=%0d", i, fc[i], cap_q[i].size() % 256); end
      for (int j = 0; j < cap_q[i].size(); j++) begin
        for (int k = 0; k < n; k++) begin
          n_cmp++;
          if (got_q[i][pos] !== exp_at(cap_q[i][j], i, k)) begin n_err++; $display("FAIL rnd_byte[%0d][%0d] got=%h exp=%h", i, pos, got_q[i][pos], exp_at(cap_q[i][j], i, k)); end
          pos++;
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
